dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is a secondary master (debug/DMA loader).
- Registers the winning request and drives the memory's address/write_data/MemWrite/MemRead for one access cycle.
- Returns read data to the winner and generates a stall for the MEM stage while it waits.
- Sits between the memory-cycle stage and the data memory.

Parameters:
ADDR_W, 32, address width of both ports and memory.
DATA_W, 32, data width.
STARVE_LIMIT, 4, consecutive lost arbitration cycles after which port 1 wins over port 0 (1..15).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
p0_req  input  1  MEM-stage request, held until p0_gnt.
p0_we  input  1  1 = write, 0 = read.
p0_addr  input  ADDR_W  byte address.
p0_wdata  input  DATA_W  write data.
p0_gnt  output  1  request accepted this cycle.
p0_rvalid  output  1  one-cycle completion pulse.
p0_rdata  output  DATA_W  read data, valid with p0_rvalid.
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1.
mem_address  output  ADDR_W  to Data_Memory address.
mem_write_data  output  DATA_W  to Data_Memory write_data.
mem_MemWrite  output  1  to Data_Memory MemWrite.
mem_MemRead  output  1  to Data_Memory MemRead.
mem_data_out  input  DATA_W  from Data_Memory data_out; combinational read of mem_address.
stall_m  output  1  p0_req & ~p0_gnt; freezes the MEM stage.
conflict_cnt  output  16  contention counter (optional feature).

Behaviour:
- FSM states: IDLE, ACCESS. Reset (rst=0, async) forces IDLE.
  - All outputs and registers reset to 0, including starve_cnt and the owner/latched request.
  - No rvalid is ever produced for an access interrupted by reset.
- IDLE, arbitration is combinational:
  - Port 1 wins if p1_req and (!p0_req or starve_cnt == STARVE_LIMIT); otherwise port 0 wins if p0_req.
  - Winner's gnt = 1 in this cycle.
  - Latch owner, we, addr, wdata; go to ACCESS.
  - No request: stay IDLE, gnt = 0.
- ACCESS, exactly 1 cycle:
  - mem_MemWrite = latched we; mem_MemRead = ~latched we; mem_address/mem_write_data = latched values.
  - At the closing edge, rdata register <= mem_data_out for reads, 0 for writes.
  - Return to IDLE. No gnt is issued in ACCESS.
- Completion:
  - pX_rvalid is registered: asserted for the owner in the cycle after ACCESS, for both reads and writes.
  - This cycle is IDLE, so a new grant may coincide with rvalid.
  - pX_rdata holds its value until the next completion for that port.
- Memory strobes:
  - mem_MemRead and mem_MemWrite are 0 outside ACCESS.
  - mem_address and mem_write_data hold their last latched value.
- Throughput and latency: max one access per 2 cycles. Latency from req (uncontended) to rvalid is 2 cycles.
- Starvation counter (starve_cnt, 4-bit):
  - Increments in each IDLE cycle where p1_req=1 and port 0 is granted; saturates at STARVE_LIMIT.
  - Cleared when port 1 is granted. Unchanged otherwise.
- Simultaneous req with starve_cnt < STARVE_LIMIT: port 0 wins and stall_m stays 0.
- Requesters must not change req, we, addr or wdata while req=1 and gnt=0. Dropping req before gnt is permitted and cancels the request.

Optional Feature:
- Macro DMEM_ARB_PERF_CNT_EN.
- Defined:
  - conflict_cnt is a 16-bit saturating counter.
  - Increments in each cycle where p0_req & p1_req are both 1 and the FSM is IDLE.
  - Stops at 16'hFFFF; cleared only by reset.
- Not defined: conflict_cnt tied to 0, no counter logic synthesized.

Test Plan:
- Reset mid-ACCESS: p0 read of 0x10 granted, rst=0 during ACCESS -> state IDLE, mem_MemRead=0, p0_rvalid never pulses, all outputs 0.
- Single p0 write then read: write 0xDEADBEEF to 0x20, then read 0x20 -> p0_gnt at cycle 0; mem_MemWrite=1 at cycle 1; p0_rvalid at cycle 2; read returns p0_rdata=0xDEADBEEF two cycles after its grant.
- Simultaneous requests: p0 read 0x04 and p1 read 0x08 in the same cycle, starve_cnt=0 -> p0_gnt first with stall_m=0; p1_gnt on the next IDLE; p1_rvalid 2 cycles later.
- Starvation: p0_req held continuously with alternating addresses, p1_req held -> p1 granted on the IDLE after starve_cnt reaches 4; stall_m=1 that cycle; starve_cnt returns to 0.
- Back-to-back: p0 issues 3 reads to 0x0, 0x4, 0x8 with req held -> grants every 2nd cycle; each rvalid coincides with the next grant; data returned in order.
- DMEM_ARB_PERF_CNT_EN defined: both ports requesting for 10 IDLE cycles -> conflict_cnt=10. Same stimulus with the macro undefined -> conflict_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester, data-memory and status signals of the two-port data-memory arbiter.
// slave: the arbiter's view; master: the requesters plus memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_gnt;
   logic              p0_rvalid;
   logic [DATA_W-1:0] p0_rdata;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_gnt;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p1_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_MemWrite;
   logic              mem_MemRead;
   logic [DATA_W-1:0] mem_data_out;

   logic              stall_m;
   logic [15:0]       conflict_cnt;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_gnt, p0_rvalid, p0_rdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
      input  mem_data_out,
      output stall_m, conflict_cnt
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_gnt, p0_rvalid, p0_rdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
      output mem_data_out,
      input  stall_m, conflict_cnt
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: combinational grant in IDLE, one memory cycle, rvalid two cycles after grant;
// losers hold req (MEM stage sees stall_m). DMEM_ARB_PERF_CNT_EN adds a saturating contention counter.
module dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic {IDLE, ACCESS} stateT;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   stateT             state;
   stateT             stateNext;
   logic              p0Win;
   logic              p1Win;
   logic              p0Gnt;
   logic              p1Gnt;
   logic              memWr;
   logic              memRd;

   logic              ownerQ;
   logic              weQ;
   logic [ADDR_W-1:0] addrQ;
   logic [DATA_W-1:0] wdataQ;
   logic [3:0]        starveCnt;

   logic              p0RvalidQ;
   logic              p1RvalidQ;
   logic [DATA_W-1:0] p0RdataQ;
   logic [DATA_W-1:0] p1RdataQ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Port 1 only pre-empts a live port-0 request once it has been starved long enough.
   always_comb begin
      stateNext = state;
      p0Gnt     = 1'b0;
      p1Gnt     = 1'b0;
      memWr     = 1'b0;
      memRd     = 1'b0;
      p1Win     = bus.p1_req && (!bus.p0_req || (starveCnt == STARVE_MAX));
      p0Win     = bus.p0_req && !p1Win;
      case (state)
         IDLE: begin
            p0Gnt = p0Win;
            p1Gnt = p1Win;
            if (p0Win || p1Win) begin
               stateNext = ACCESS;
            end
         end
         ACCESS: begin
            memWr     = weQ;
            memRd     = !weQ;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ownerQ <= 1'b0;
         weQ    <= 1'b0;
         addrQ  <= '0;
         wdataQ <= '0;
      end else if (p1Gnt) begin
         ownerQ <= 1'b1;
         weQ    <= bus.p1_we;
         addrQ  <= bus.p1_addr;
         wdataQ <= bus.p1_wdata;
      end else if (p0Gnt) begin
         ownerQ <= 1'b0;
         weQ    <= bus.p0_we;
         addrQ  <= bus.p0_addr;
         wdataQ <= bus.p0_wdata;
      end
   end

   // Completion is captured at the edge closing ACCESS; writes return zero data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0RvalidQ <= 1'b0;
         p1RvalidQ <= 1'b0;
         p0RdataQ  <= '0;
         p1RdataQ  <= '0;
      end else begin
         p0RvalidQ <= (state == ACCESS) && !ownerQ;
         p1RvalidQ <= (state == ACCESS) && ownerQ;
         if (state == ACCESS) begin
            if (ownerQ) begin
               p1RdataQ <= weQ ? '0 : bus.mem_data_out;
            end else begin
               p0RdataQ <= weQ ? '0 : bus.mem_data_out;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starveCnt <= 4'd0;
      end else if (p1Gnt) begin
         starveCnt <= 4'd0;
      end else if (p0Gnt && bus.p1_req && (starveCnt != STARVE_MAX)) begin
         starveCnt <= starveCnt + 4'd1;
      end
   end

`ifdef DMEM_ARB_PERF_CNT_EN
   logic [15:0] conflictCnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conflictCnt <= 16'h0000;
      end else if ((state == IDLE) && bus.p0_req && bus.p1_req && (conflictCnt != 16'hFFFF)) begin
         conflictCnt <= conflictCnt + 16'd1;
      end
   end

   assign bus.conflict_cnt = conflictCnt;
`else
   assign bus.conflict_cnt = 16'h0000;
`endif

   assign bus.p0_gnt         = p0Gnt;
   assign bus.p1_gnt         = p1Gnt;
   assign bus.p0_rvalid      = p0RvalidQ;
   assign bus.p1_rvalid      = p1RvalidQ;
   assign bus.p0_rdata       = p0RdataQ;
   assign bus.p1_rdata       = p1RdataQ;
   assign bus.mem_address    = addrQ;
   assign bus.mem_write_data = wdataQ;
   assign bus.mem_MemWrite   = memWr;
   assign bus.mem_MemRead    = memRd;
   assign bus.stall_m        = bus.p0_req && !p0Gnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data memory behind it.
module tb_dmem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nChecks = 0;
   int nBad    = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] tbMem  [256];
   logic [DW-1:0] refMem [256];
   assign bus.mem_data_out = tbMem[bus.mem_address[9:2]];
   always @(posedge clk) if (bus.mem_MemWrite) tbMem[bus.mem_address[9:2]] <= bus.mem_write_data;

   logic [DW-1:0] expQ0[$];
   logic [DW-1:0] expQ1[$];
   int            gntCycQ0[$];
   int            gntCycQ1[$];
   txT            txQ0[$];
   txT            txQ1[$];
   int            firstGnt[2];
   int            lastGnt[2];
   logic          stallAtGnt1;

   function automatic logic [DW-1:0] seedWord(input int i);
      return 32'(i) * 32'h0001_0003 + 32'h5A00_0000;
   endfunction

   function automatic txT mkTx(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      txT t;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      return t;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive(input int port, input logic req, input txT t);
      if (port == 0) begin
         bus.p0_req = req; bus.p0_we = t.we; bus.p0_addr = t.addr; bus.p0_wdata = t.wdata;
      end else begin
         bus.p1_req = req; bus.p1_we = t.we; bus.p1_addr = t.addr; bus.p1_wdata = t.wdata;
      end
   endtask

   // Pops the port's stimulus queue, holding req across back-to-back transactions.
   task automatic runPort(input int port, input bit checkGap);
      txT   t;
      logic got;
      int   prev;
      int   n;
      prev = -1;
      n    = 0;
      while ((port == 0 ? txQ0.size() : txQ1.size()) != 0) begin
         t = (port == 0) ? txQ0.pop_front() : txQ1.pop_front();
         drive(port, 1'b1, t);
         got = 1'b0;
         for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            got = (port == 0) ? bus.p0_gnt : bus.p1_gnt;
         end
         if (!got) begin
            checkVal($sformatf("p%0dGntTimeout", port), 32'd0, 32'd1);
            break;
         end
         if (port == 0) begin
            expQ0.push_back(t.we ? 32'h0 : refMem[t.addr[9:2]]);
            gntCycQ0.push_back(cyc);
            checkVal("p0GntNoStall", 32'(bus.stall_m), 32'd0);
         end else begin
            expQ1.push_back(t.we ? 32'h0 : refMem[t.addr[9:2]]);
            gntCycQ1.push_back(cyc);
            stallAtGnt1 = bus.stall_m;
         end
         if (t.we) refMem[t.addr[9:2]] = t.wdata;
         if (checkGap && prev >= 0) checkVal("gntGap", 32'(cyc - prev), 32'd2);
         if (n == 0) firstGnt[port] = cyc;
         lastGnt[port] = cyc;
         prev = cyc;
         n++;
         @(posedge clk); #1;
      end
      drive(port, 1'b0, '0);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((expQ0.size() != 0 || expQ1.size() != 0) && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (expQ0.size() != 0 || expQ1.size() != 0) checkVal("drainTimeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic doReset();
      rst = 1'b0;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      repeat (2) @(posedge clk);
      #1;
      expQ0.delete(); expQ1.delete(); gntCycQ0.delete(); gntCycQ1.delete();
      stallAtGnt1 = 1'b0;
      rst = 1'b1;
   endtask

   task automatic watchWrite();
      logic got;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         @(negedge clk);
         got = bus.p0_gnt;
      end
      checkVal("wrGnt", 32'(got), 32'd1);
      @(negedge clk);
      checkVal("wrMemWrite", 32'(bus.mem_MemWrite), 32'd1);
      checkVal("wrMemRead", 32'(bus.mem_MemRead), 32'd0);
      checkVal("wrMemAddr", bus.mem_address, 32'h20);
      checkVal("wrMemData", bus.mem_write_data, 32'hDEADBEEF);
      @(negedge clk);
      checkVal("wrRvalid", 32'(bus.p0_rvalid), 32'd1);
      checkVal("wrStrobeOff", 32'(bus.mem_MemWrite), 32'd0);
   endtask

   // Completion monitor: every rvalid must match the oldest expectation and arrive two cycles after its grant.
   always @(negedge clk) begin
      if (rst && bus.p0_rvalid) begin
         if (expQ0.size() == 0) checkVal("p0SpuriousRvalid", 32'd1, 32'd0);
         else begin
            checkVal("p0Rdata", bus.p0_rdata, expQ0.pop_front());
            checkVal("p0Latency", 32'(cyc - gntCycQ0.pop_front()), 32'd2);
         end
      end
      if (rst && bus.p1_rvalid) begin
         if (expQ1.size() == 0) checkVal("p1SpuriousRvalid", 32'd1, 32'd0);
         else begin
            checkVal("p1Rdata", bus.p1_rdata, expQ1.pop_front());
            checkVal("p1Latency", 32'(cyc - gntCycQ1.pop_front()), 32'd2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            rvCount;
      logic [15:0]   expConf;
      for (int i = 0; i < 256; i++) begin
         tbMem[i]  <= seedWord(i);
         refMem[i]  = seedWord(i);
      end
      stallAtGnt1 = 1'b0;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("rstP0Gnt", 32'(bus.p0_gnt), 32'd0);
      checkVal("rstP1Gnt", 32'(bus.p1_gnt), 32'd0);
      checkVal("rstP0Rvalid", 32'(bus.p0_rvalid), 32'd0);
      checkVal("rstP1Rvalid", 32'(bus.p1_rvalid), 32'd0);
      checkVal("rstP0Rdata", bus.p0_rdata, 32'd0);
      checkVal("rstP1Rdata", bus.p1_rdata, 32'd0);
      checkVal("rstMemRead", 32'(bus.mem_MemRead), 32'd0);
      checkVal("rstMemWrite", 32'(bus.mem_MemWrite), 32'd0);
      checkVal("rstMemAddr", bus.mem_address, 32'd0);
      checkVal("rstMemWdata", bus.mem_write_data, 32'd0);
      checkVal("rstStall", 32'(bus.stall_m), 32'd0);
      checkVal("rstConflict", 32'(bus.conflict_cnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Reset arriving in the middle of ACCESS
      @(posedge clk); #1;
      drive(0, 1'b1, mkTx(1'b0, 32'h10, 32'h0));
      @(negedge clk);
      checkVal("rmaGnt", 32'(bus.p0_gnt), 32'd1);
      @(posedge clk); #1;
      drive(0, 1'b0, '0);
      checkVal("rmaMemRead", 32'(bus.mem_MemRead), 32'd1);
      checkVal("rmaMemAddr", bus.mem_address, 32'h10);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkVal("rmaRstMemRead", 32'(bus.mem_MemRead), 32'd0);
      checkVal("rmaRstMemAddr", bus.mem_address, 32'd0);
      checkVal("rmaRstRvalid", 32'(bus.p0_rvalid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      rvCount = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.p0_rvalid) rvCount++;
      end
      checkVal("rmaNoRvalid", 32'(rvCount), 32'd0);

      // Single write then read back
      doReset();
      txQ0.push_back(mkTx(1'b1, 32'h20, 32'hDEADBEEF));
      fork
         runPort(0, 1'b0);
         watchWrite();
      join
      drain();
      txQ0.push_back(mkTx(1'b0, 32'h20, 32'h0));
      runPort(0, 1'b0);
      drain();
      checkVal("rdHold", bus.p0_rdata, 32'hDEADBEEF);

      // Simultaneous requests, starve count at zero
      doReset();
      txQ0.push_back(mkTx(1'b0, 32'h04, 32'h0));
      txQ1.push_back(mkTx(1'b0, 32'h08, 32'h0));
      fork
         runPort(0, 1'b0);
         runPort(1, 1'b0);
      join
      drain();
      checkVal("simP1After", 32'(lastGnt[1] - firstGnt[0]), 32'd2);

      // Starvation: p0 held continuously, p1 waiting
      doReset();
      for (int i = 0; i < 6; i++) txQ0.push_back(mkTx(1'b0, (i % 2 == 0) ? 32'h40 : 32'h44, 32'h0));
      txQ1.push_back(mkTx(1'b0, 32'h80, 32'h0));
      fork
         runPort(0, 1'b0);
         runPort(1, 1'b0);
      join
      drain();
      checkVal("starveP1Gnt", 32'(firstGnt[1] - firstGnt[0]), 32'd8);
      checkVal("starveStall", 32'(stallAtGnt1), 32'd1);
      checkVal("starveP0Resume", 32'(lastGnt[0] - firstGnt[0]), 32'd12);
      checkVal("starveCntClr", 32'(dut.starveCnt), 32'd0);

      // Back-to-back reads with req held
      doReset();
      txQ0.push_back(mkTx(1'b0, 32'h0, 32'h0));
      txQ0.push_back(mkTx(1'b0, 32'h4, 32'h0));
      txQ0.push_back(mkTx(1'b0, 32'h8, 32'h0));
      runPort(0, 1'b1);
      drain();

      // p1 write/read mix, then contention for the conflict counter
      doReset();
      txQ1.push_back(mkTx(1'b1, 32'h300, 32'h1234_5678));
      txQ1.push_back(mkTx(1'b0, 32'h300, 32'h0));
      runPort(1, 1'b1);
      drain();

      doReset();
      for (int i = 0; i < 10; i++) txQ0.push_back(mkTx(1'b0, 32'h100 + 32'(4 * i), 32'h0));
      txQ1.push_back(mkTx(1'b0, 32'h200, 32'h0));
      txQ1.push_back(mkTx(1'b0, 32'h204, 32'h0));
      fork
         runPort(0, 1'b0);
         runPort(1, 1'b0);
      join
      drain();
      checkVal("conflictP1Gap", 32'(lastGnt[1] - firstGnt[1]), 32'd10);
`ifdef DMEM_ARB_PERF_CNT_EN
      expConf = 16'd10;
`else
      expConf = 16'd0;
`endif
      checkVal("conflictCnt", 32'(bus.conflict_cnt), 32'(expConf));

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end
endmodule
